// File: rtl/fir_s2p_buffer_if.sv
// Handshake and frame bus between the FIR stage, the serial-to-parallel
// buffer and the FFT stage.
interface fir_s2p_buffer_if #(
  parameter int DW = 16
);

  logic          fir_valid;
  logic [DW-1:0] fir_d;
  logic          fft_ack;

  logic [DW-1:0] out_d0;
  logic [DW-1:0] out_d1;
  logic [DW-1:0] out_d2;
  logic [DW-1:0] out_d3;
  logic [DW-1:0] out_d4;
  logic [DW-1:0] out_d5;
  logic [DW-1:0] out_d6;
  logic [DW-1:0] out_d7;
  logic [DW-1:0] out_d8;
  logic [DW-1:0] out_d9;
  logic [DW-1:0] out_d10;
  logic [DW-1:0] out_d11;
  logic [DW-1:0] out_d12;
  logic [DW-1:0] out_d13;
  logic [DW-1:0] out_d14;
  logic [DW-1:0] out_d15;
  logic          out_valid;
  logic          overrun;

  // Master side drives samples and acknowledges; it observes the frame.
  modport master (
    output fir_valid, fir_d, fft_ack,
    input  out_d0, out_d1, out_d2, out_d3, out_d4, out_d5, out_d6, out_d7,
           out_d8, out_d9, out_d10, out_d11, out_d12, out_d13, out_d14, out_d15,
           out_valid, overrun
  );

  modport slave (
    input  fir_valid, fir_d, fft_ack,
    output out_d0, out_d1, out_d2, out_d3, out_d4, out_d5, out_d6, out_d7,
           out_d8, out_d9, out_d10, out_d11, out_d12, out_d13, out_d14, out_d15,
           out_valid, overrun
  );

endinterface

// File: rtl/fir_s2p_buffer.sv
// Collects 16 consecutive FIR samples into a parallel frame for the FFT,
// with a registered frame-valid flag and a sticky overrun indicator.
module fir_s2p_buffer #(
  parameter int DW = 16,
  parameter int N  = 16
) (
  input logic              clk,
  input logic              rst,
  fir_s2p_buffer_if.slave  bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q,      cnt_d;
  logic [DW-1:0] shift_q     [N-1];
  logic [DW-1:0] shift_d     [N-1];
  logic [DW-1:0] frame_q     [N];
  logic [DW-1:0] frame_d     [N];
  logic          outValid_q, outValid_d;
  logic          overrun_q,  overrun_d;
  logic          frameDone;

  assign frameDone = bus.fir_valid && (cnt_q == LAST);

  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    frame_d    = frame_q;
    outValid_d = outValid_q;
    overrun_d  = overrun_q;

    // Any gap in fir_valid discards the partial frame; stale shift entries
    // are harmless since a full frame always refills all of them.
    if (bus.fir_valid) begin
      for (int i = 0; i < N - 2; i++) begin
        shift_d[i] = shift_q[i + 1];
      end
      shift_d[N-2] = bus.fir_d;
      cnt_d = frameDone ? '0 : cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end

    if (frameDone) begin
      for (int i = 0; i < N - 1; i++) begin
        frame_d[i] = shift_q[i];
      end
      frame_d[N-1] = bus.fir_d;
      outValid_d   = 1'b1;
      if (outValid_q && !bus.fft_ack) begin
        overrun_d = 1'b1;
      end
    end else if (outValid_q && bus.fft_ack) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      outValid_q <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < N - 1; i++) begin
        shift_q[i] <= '0;
      end
      for (int i = 0; i < N; i++) begin
        frame_q[i] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      outValid_q <= outValid_d;
      overrun_q  <= overrun_d;
      shift_q    <= shift_d;
      frame_q    <= frame_d;
    end
  end

  assign bus.out_d0    = frame_q[0];
  assign bus.out_d1    = frame_q[1];
  assign bus.out_d2    = frame_q[2];
  assign bus.out_d3    = frame_q[3];
  assign bus.out_d4    = frame_q[4];
  assign bus.out_d5    = frame_q[5];
  assign bus.out_d6    = frame_q[6];
  assign bus.out_d7    = frame_q[7];
  assign bus.out_d8    = frame_q[8];
  assign bus.out_d9    = frame_q[9];
  assign bus.out_d10   = frame_q[10];
  assign bus.out_d11   = frame_q[11];
  assign bus.out_d12   = frame_q[12];
  assign bus.out_d13   = frame_q[13];
  assign bus.out_d14   = frame_q[14];
  assign bus.out_d15   = frame_q[15];
  assign bus.out_valid = outValid_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_fir_s2p_buffer.sv
// Directed self-checking bench for fir_s2p_buffer: reset, framing, gaps,
// overrun, simultaneous ack/completion and mid-frame reset.
module tb_fir_s2p_buffer;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;
  int   riseCount;
  logic prevValid;

  fir_s2p_buffer_if #(.DW(16)) bus ();

  fir_s2p_buffer #(.DW(16), .N(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs from a falling edge, then wait for the next
  // falling edge so outputs are sampled away from the rising edge.
  task automatic applyStimulus(input logic valid, input logic [15:0] data,
                               input logic ack);
    bus.fir_valid = valid;
    bus.fir_d     = data;
    bus.fft_ack   = ack;
    @(negedge clk);
    if (bus.out_valid && !prevValid) riseCount++;
    prevValid = bus.out_valid;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  initial begin
    assertCount   = 0;
    failCount     = 0;
    riseCount     = 0;
    prevValid     = 1'b0;
    rst           = 1'b0;
    bus.fir_valid = 1'b0;
    bus.fir_d     = '0;
    bus.fft_ack   = 1'b0;

    // Reset held low with random activity on the inputs
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'($urandom_range(1)), 16'($urandom), 1'($urandom_range(1)));
    end
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("reset_overrun",   32'(bus.overrun),   32'h0);
    checkOutput("reset_out_d0",    32'(bus.out_d0),    32'h0);
    checkOutput("reset_out_d15",   32'(bus.out_d15),   32'h0);
    rst = 1'b1;

    // Basic frame 0x0001..0x0010
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 16'(i + 1), 1'b0);
    end
    checkOutput("basic_out_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("basic_out_d0",    32'(bus.out_d0),    32'h0001);
    checkOutput("basic_out_d7",    32'(bus.out_d7),    32'h0008);
    checkOutput("basic_out_d15",   32'(bus.out_d15),   32'h0010);
    checkOutput("basic_overrun",   32'(bus.overrun),   32'h0);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("ack_out_valid",   32'(bus.out_valid), 32'h0);
    checkOutput("ack_held_d0",     32'(bus.out_d0),    32'h0001);
    checkOutput("ack_held_d15",    32'(bus.out_d15),   32'h0010);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("idle_ack_valid",  32'(bus.out_valid), 32'h0);
    checkOutput("idle_ack_ovr",    32'(bus.overrun),   32'h0);

    // Partial frame of 10, one idle cycle, then a full frame 0x0100..0x010F
    riseCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 16'(16'h0200 + i), 1'b0);
    end
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("gap_no_valid",    32'(bus.out_valid), 32'h0);
    checkOutput("gap_held_d0",     32'(bus.out_d0),    32'h0001);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 16'(16'h0100 + i), 1'b0);
    end
    checkOutput("gap_out_d0",      32'(bus.out_d0),    32'h0100);
    checkOutput("gap_out_d9",      32'(bus.out_d9),    32'h0109);
    checkOutput("gap_out_d15",     32'(bus.out_d15),   32'h010F);
    checkOutput("gap_rise_count",  32'(riseCount),     32'h1);
    applyStimulus(1'b0, 16'h0, 1'b1);

    // 32 samples with no ack: second frame overwrites the first
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0);
      if (i == 15) begin
        checkOutput("ovr_first_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("ovr_first_flag",  32'(bus.overrun),   32'h0);
      end
    end
    checkOutput("ovr_flag",        32'(bus.overrun),   32'h1);
    checkOutput("ovr_out_valid",   32'(bus.out_valid), 32'h1);
    checkOutput("ovr_out_d0",      32'(bus.out_d0),    32'h0010);
    checkOutput("ovr_out_d15",     32'(bus.out_d15),   32'h001F);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("ovr_ack_valid",   32'(bus.out_valid), 32'h0);
    checkOutput("ovr_sticky",      32'(bus.overrun),   32'h1);
    #2 rst = 1'b0;
    #1;
    checkOutput("ovr_reset_flag",  32'(bus.overrun),   32'h0);
    checkOutput("ovr_reset_d0",    32'(bus.out_d0),    32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Ack on the same edge as the second frame completes
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 16'(16'h0300 + i), 1'b0);
    end
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 16'(16'h0400 + i), 1'b0);
    end
    applyStimulus(1'b1, 16'h040F, 1'b1);
    checkOutput("simul_valid",     32'(bus.out_valid), 32'h1);
    checkOutput("simul_overrun",   32'(bus.overrun),   32'h0);
    checkOutput("simul_out_d0",    32'(bus.out_d0),    32'h0400);
    checkOutput("simul_out_d15",   32'(bus.out_d15),   32'h040F);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("simul_ack_valid", 32'(bus.out_valid), 32'h0);

    // Reset pulse mid-frame, then a frame of negative samples
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'(16'h0500 + i), 1'b0);
    end
    bus.fir_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_async_d0", 32'(bus.out_d0),    32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 16'(16'h8000 + i), 1'b0);
    end
    checkOutput("midrst_valid",    32'(bus.out_valid), 32'h1);
    checkOutput("midrst_out_d0",   32'(bus.out_d0),    32'h8000);
    checkOutput("midrst_out_d8",   32'(bus.out_d8),    32'h8008);
    checkOutput("midrst_out_d15",  32'(bus.out_d15),   32'h800F);
    checkOutput("midrst_overrun",  32'(bus.overrun),   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
